// File: rtl/fft_twiddle_gen.sv
// rtl/fft_twiddle_gen.sv - radix-2 DIT twiddle stream generator with quarter-wave cosine ROM
module fft_twiddle_gen #(
    parameter int N_LOG2 = 8,
    parameter int W_BIT  = 12,
    parameter int W_MAX  = 1024
) (
    input  logic                      iCLK,
    input  logic                      iRESET,
    input  logic                      iSTART,
    input  logic [$clog2(N_LOG2)-1:0] iSTAGE,
    input  logic                      iINV,
    output logic signed [W_BIT-1:0]   oW_RE,
    output logic signed [W_BIT-1:0]   oW_IM,
    output logic                      oVALID,
    input  logic                      iREADY,
    output logic                      oLAST,
    output logic                      oBUSY,
    output logic                      oDONE
);
    localparam int SW = $clog2(N_LOG2);
    localparam int JW = N_LOG2 - 1;      // butterfly index / k width
    localparam int MW = N_LOG2 - 2;      // offset within a quadrant
    localparam int Q  = 1 << MW;         // N/4
    localparam logic [JW-1:0] J_LAST = {JW{1'b1}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    // Quarter-wave cosine sample, rounded to nearest; Taylor series keeps it elaboration-only.
    function automatic int cos_q(input int m);
        real x;
        real term;
        real sum;
        x    = 6.283185307179586 * real'(m) / real'(1 << N_LOG2);
        term = 1.0;
        sum  = 1.0;
        for (int i = 1; i < 24; i++) begin
            term = -term * x * x / real'((2 * i - 1) * (2 * i));
            sum  = sum + term;
        end
        return $rtoi(real'(W_MAX) * sum + 0.5);
    endfunction

    logic signed [W_BIT-1:0] w_rom [0:Q];
    for (genvar g = 0; g <= Q; g++) begin : g_rom
        localparam int C_VAL = cos_q(g);
        assign w_rom[g] = W_BIT'(C_VAL);
    end

    state_t                  r_state;
    state_t                  w_state_nx;
    logic [JW-1:0]           r_j;
    logic [SW-1:0]           r_stage;
    logic                    r_inv;
    logic                    r1_valid;
    logic                    r1_quad;
    logic [MW-1:0]           r1_m;
    logic                    r1_last;
    logic                    r2_valid;
    logic                    r2_last;
    logic signed [W_BIT-1:0] r2_re;
    logic signed [W_BIT-1:0] r2_im;
    logic                    r_done;

    logic                    w_stall;
    logic                    w_issue;
    logic                    w_accept_last;
    logic [JW-1:0]           w_mask;
    logic [SW-1:0]           w_shamt;
    logic [JW-1:0]           w_k;
    logic [JW-1:0]           w_idx_m;
    logic [JW-1:0]           w_idx_qm;
    logic signed [W_BIT-1:0] w_c_m;
    logic signed [W_BIT-1:0] w_c_qm;
    logic signed [W_BIT-1:0] w_re;
    logic signed [W_BIT-1:0] w_im_fwd;
    logic signed [W_BIT-1:0] w_im;

    // A presented but unaccepted beat freezes everything behind it.
    assign w_stall       = r2_valid & ~iREADY;
    assign w_accept_last = r2_valid & iREADY & r2_last;

    // k = (j mod 2^s) << (N_LOG2-1-s)
    assign w_mask  = ~({JW{1'b1}} << r_stage);
    assign w_shamt = SW'(JW) - r_stage;
    assign w_k     = (r_j & w_mask) << w_shamt;

    // Quadrant symmetry: second quadrant reuses the same ROM mirrored and negated.
    assign w_idx_m  = {1'b0, r1_m};
    assign w_idx_qm = JW'(Q) - w_idx_m;
    assign w_c_m    = w_rom[w_idx_m];
    assign w_c_qm   = w_rom[w_idx_qm];
    assign w_re     = r1_quad ? -w_c_qm : w_c_m;
    assign w_im_fwd = r1_quad ? -w_c_m  : -w_c_qm;
    assign w_im     = r_inv ? -w_im_fwd : w_im_fwd;

    // State register.
    always_ff @(posedge iCLK) begin
        if (iRESET) r_state <= S_IDLE;
        else        r_state <= w_state_nx;
    end

    // Next state and issue decision.
    always_comb begin
        w_state_nx = r_state;
        w_issue    = 1'b0;
        case (r_state)
            S_IDLE:  if (iSTART) w_state_nx = S_RUN;
            S_RUN: begin
                if (!w_stall) begin
                    w_issue = 1'b1;
                    if (r_j == J_LAST) w_state_nx = S_DRAIN;
                end
            end
            S_DRAIN: if (w_accept_last) w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Stage parameters latched on start; butterfly counter advances on each issue.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            r_j     <= '0;
            r_stage <= '0;
            r_inv   <= 1'b0;
        end else if (r_state == S_IDLE && iSTART) begin
            r_j     <= '0;
            r_stage <= iSTAGE;
            r_inv   <= iINV;
        end else if (w_issue) begin
            r_j <= r_j + 1'b1;
        end
    end

    // Two-stage pipeline: k/quadrant split, then ROM lookup with sign handling.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            r1_valid <= 1'b0;
            r1_quad  <= 1'b0;
            r1_m     <= '0;
            r1_last  <= 1'b0;
            r2_valid <= 1'b0;
            r2_last  <= 1'b0;
            r2_re    <= '0;
            r2_im    <= '0;
        end else if (!w_stall) begin
            r1_valid <= w_issue;
            r1_quad  <= w_k[JW-1];
            r1_m     <= w_k[MW-1:0];
            r1_last  <= (r_j == J_LAST);
            r2_valid <= r1_valid;
            if (r1_valid) begin
                r2_last <= r1_last;
                r2_re   <= w_re;
                r2_im   <= w_im;
            end else begin
                r2_last <= 1'b0;
            end
        end
    end

    // Completion pulse follows acceptance of the final beat.
    always_ff @(posedge iCLK) begin
        if (iRESET) r_done <= 1'b0;
        else        r_done <= w_accept_last;
    end

    assign oW_RE  = r2_re;
    assign oW_IM  = r2_im;
    assign oVALID = r2_valid;
    assign oLAST  = r2_valid & r2_last;
    assign oBUSY  = (r_state != S_IDLE);
    assign oDONE  = r_done;
endmodule

// File: tb/tb_fft_twiddle_gen.sv
// tb/tb_fft_twiddle_gen.sv - scoreboard bench for fft_twiddle_gen (N=8 directed, N=256 sweep)
module tb_fft_twiddle_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // N=8 instance
    logic               a_start = 0, a_inv = 0, a_ready = 1;
    logic [1:0]         a_stage = 0;
    logic signed [11:0] a_re, a_im;
    logic               a_valid, a_last, a_busy, a_done;

    fft_twiddle_gen #(.N_LOG2(3), .W_BIT(12), .W_MAX(1024)) u_a (
        .iCLK(clk), .iRESET(rst), .iSTART(a_start), .iSTAGE(a_stage), .iINV(a_inv),
        .oW_RE(a_re), .oW_IM(a_im), .oVALID(a_valid), .iREADY(a_ready),
        .oLAST(a_last), .oBUSY(a_busy), .oDONE(a_done));

    // N=256 instance
    logic               b_start = 0, b_inv = 0, b_ready = 1;
    logic [2:0]         b_stage = 0;
    logic signed [11:0] b_re, b_im;
    logic               b_valid, b_last, b_busy, b_done;

    fft_twiddle_gen #(.N_LOG2(8), .W_BIT(12), .W_MAX(1024)) u_b (
        .iCLK(clk), .iRESET(rst), .iSTART(b_start), .iSTAGE(b_stage), .iINV(b_inv),
        .oW_RE(b_re), .oW_IM(b_im), .oVALID(b_valid), .iREADY(b_ready),
        .oLAST(b_last), .oBUSY(b_busy), .oDONE(b_done));

    typedef struct { int re; int im; bit last; } beat_t;
    typedef struct { real re; real im; bit last; } rbeat_t;
    beat_t  qa[$];
    rbeat_t qb[$];
    int a_last_cyc = 0;
    int b_last_cyc = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic push_a(input int re, input int im, input bit last);
        beat_t e;
        e.re = re; e.im = im; e.last = last;
        qa.push_back(e);
    endtask

    // Monitor for the N=8 instance
    always @(negedge clk) begin
        beat_t e;
        if (!rst && a_valid && a_ready) begin
            if (qa.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL a_unexpected_beat actual=(%0d,%0d) expected=none", a_re, a_im);
            end else begin
                e = qa.pop_front();
                chk("a_re", int'(a_re), e.re);
                chk("a_im", int'(a_im), e.im);
                chk("a_last", int'(a_last), int'(e.last));
            end
            if (a_last) a_last_cyc = cyc;
        end
    end

    // Monitor for the N=256 instance, tolerance 1 LSB against real model
    always @(negedge clk) begin
        rbeat_t e;
        real dre, dim;
        if (!rst && b_valid && b_ready) begin
            n_checks++;
            if (qb.size() == 0) begin
                n_errors++;
                $display("FAIL b_unexpected_beat actual=(%0d,%0d) expected=none", b_re, b_im);
            end else begin
                e = qb.pop_front();
                dre = real'(b_re) - e.re;
                dim = real'(b_im) - e.im;
                if (dre > 1.0 || dre < -1.0 || dim > 1.0 || dim < -1.0 || b_last != e.last) begin
                    n_errors++;
                    $display("FAIL b_beat actual=(%0d,%0d,last=%0d) expected=(%f,%f,last=%0d)",
                             b_re, b_im, b_last, e.re, e.im, e.last);
                end
            end
            if (b_last) b_last_cyc = cyc;
        end
    end

    task automatic start_a(input int s, input bit inv, output int cs);
        a_stage = 2'(s); a_inv = inv; a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        cs = cyc;
    endtask

    // span < 0 skips the start-to-done timing check
    task automatic wait_done_a(input string nm, input int cs, input int span);
        int t;
        t = 0;
        do begin @(negedge clk); t++; end while (!a_done && t < 300);
        if (!a_done) begin
            n_checks++; n_errors++;
            $display("FAIL %s_timeout actual=no_done expected=done", nm);
        end else begin
            chk({nm, "_done_after_last"}, cyc, a_last_cyc + 1);
            if (span >= 0) chk({nm, "_span"}, cyc - cs, span);
        end
        chk({nm, "_q_empty"}, qa.size(), 0);
        @(negedge clk);
        chk({nm, "_done_pulse"}, int'(a_done), 0);
        chk({nm, "_busy_idle"}, int'(a_busy), 0);
    endtask

    task automatic run_b(input int s, input bit inv);
        rbeat_t e;
        int k, t;
        real ang;
        for (int j = 0; j < 128; j++) begin
            k = (j & ((1 << s) - 1)) << (7 - s);
            ang = 2.0 * 3.141592653589793 * real'(k) / 256.0;
            e.re = 1024.0 * $cos(ang);
            e.im = (inv ? 1.0 : -1.0) * 1024.0 * $sin(ang);
            e.last = (j == 127);
            qb.push_back(e);
        end
        b_stage = 3'(s); b_inv = inv; b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (!b_done && t < 400);
        if (!b_done) begin
            n_checks++; n_errors++;
            $display("FAIL b_s%0d_timeout actual=no_done expected=done", s);
        end else begin
            chk("b_done_after_last", cyc, b_last_cyc + 1);
        end
        chk("b_q_empty", qb.size(), 0);
    endtask

    initial begin
        int cs;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        // reset state
        chk("rst_valid", int'(a_valid), 0);
        chk("rst_last",  int'(a_last),  0);
        chk("rst_busy",  int'(a_busy),  0);
        chk("rst_done",  int'(a_done),  0);
        chk("rst_re",    int'(a_re),    0);
        chk("rst_im",    int'(a_im),    0);
        chk("rst_b_valid", int'(b_valid), 0);

        // T1: s=2 forward, with latency checks
        push_a(1024, 0, 0); push_a(724, -724, 0); push_a(0, -1024, 0); push_a(-724, -724, 1);
        start_a(2, 0, cs);
        chk("t1_busy", int'(a_busy), 1);
        @(negedge clk); chk("t1_lat0", int'(a_valid), 0);
        @(negedge clk); chk("t1_lat1", int'(a_valid), 0);
        @(negedge clk); chk("t1_lat2", int'(a_valid), 1);
        wait_done_a("t1", cs, 6);

        // T2: s=1 then s=0
        push_a(1024, 0, 0); push_a(0, -1024, 0); push_a(1024, 0, 0); push_a(0, -1024, 1);
        start_a(1, 0, cs);
        wait_done_a("t2s1", cs, 6);
        push_a(1024, 0, 0); push_a(1024, 0, 0); push_a(1024, 0, 0); push_a(1024, 0, 1);
        start_a(0, 0, cs);
        wait_done_a("t2s0", cs, 6);

        // T3: s=2 inverse
        push_a(1024, 0, 0); push_a(724, 724, 0); push_a(0, 1024, 0); push_a(-724, 724, 1);
        start_a(2, 1, cs);
        wait_done_a("t3", cs, 6);

        // T4: backpressure on beat 2 for 3 cycles
        push_a(1024, 0, 0); push_a(724, -724, 0); push_a(0, -1024, 0); push_a(-724, -724, 1);
        start_a(2, 0, cs);
        repeat (3) @(posedge clk);
        #1 a_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", int'(a_valid), 1);
            chk("t4_hold_re", int'(a_re), 724);
            chk("t4_hold_im", int'(a_im), -724);
        end
        @(posedge clk);
        #1 a_ready = 1'b1;
        wait_done_a("t4", cs, 9);

        // T5: start while busy is ignored
        push_a(1024, 0, 0); push_a(724, -724, 0); push_a(0, -1024, 0); push_a(-724, -724, 1);
        start_a(2, 0, cs);
        @(posedge clk); #1;
        a_stage = 2'd1; a_inv = 1'b1; a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        wait_done_a("t5", cs, 6);

        // T6: reset mid-stage after beat 2
        push_a(1024, 0, 0); push_a(724, -724, 0); push_a(0, -1024, 0); push_a(-724, -724, 1);
        start_a(2, 0, cs);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        chk("t6_beats_before_rst", qa.size(), 2);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_valid", int'(a_valid), 0);
        chk("t6_busy",  int'(a_busy),  0);
        chk("t6_done",  int'(a_done),  0);
        qa.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_no_done", int'(a_done), 0);
        end
        push_a(1024, 0, 0); push_a(1024, 0, 0); push_a(1024, 0, 0); push_a(1024, 0, 1);
        start_a(0, 0, cs);
        wait_done_a("t6_restart", cs, 6);

        // N=256 sweep over all stages, alternating direction
        for (int s = 0; s < 8; s++) run_b(s, s[0]);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
